// File: rtl/cnt_share_arb.sv
// rtl/cnt_share_arb.sv - round-robin sharing of one down-counter timer among NREQ requesters (optional CNT_ARB_ABORT_EN: owner may abort)
module cnt_share_arb #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 4,
    localparam int OW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      count,
    output logic [NREQ-1:0]       done
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t          state, state_nxt;
    logic [OW-1:0]   last_owner, last_owner_nxt;
    logic [OW-1:0]   owner_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [NREQ-1:0] done_nxt;
    logic            busy_nxt;
    logic [WIDTH-1:0] count_nxt;

    logic [OW-1:0]   win;
    logic            any_req;
    int              idx;

    // Round-robin pick: first active request after the last owner, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(last_owner) + 1 + k) % NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                win     = OW'(idx);
            end
        end
    end

    // Next-state and registered-output logic; everything holds unless changed.
    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        owner_nxt      = owner;
        busy_nxt       = busy;
        count_nxt      = count;
        done_nxt       = done;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    owner_nxt    = win;
                    busy_nxt     = 1'b1;
                    count_nxt    = len[int'(win)*WIDTH +: WIDTH];
                    state_nxt    = COUNT;
                end
            end
            COUNT: begin
`ifdef CNT_ARB_ABORT_EN
                // Owner dropped its request: release the timer without a done pulse.
                if (!req[owner]) begin
                    gnt_nxt        = '0;
                    busy_nxt       = 1'b0;
                    count_nxt      = '0;
                    last_owner_nxt = owner;
                    state_nxt      = IDLE;
                end else
`endif
                if (count != '0) begin
                    count_nxt = count - WIDTH'(1);
                end else begin
                    // gnt is one-hot on the owner, so it doubles as the done mask.
                    done_nxt       = gnt;
                    gnt_nxt        = '0;
                    busy_nxt       = 1'b0;
                    last_owner_nxt = owner;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                done_nxt  = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; last_owner resets so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            count      <= '0;
            done       <= '0;
            last_owner <= OW'(NREQ - 1);
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            owner      <= owner_nxt;
            busy       <= busy_nxt;
            count      <= count_nxt;
            done       <= done_nxt;
            last_owner <= last_owner_nxt;
        end
    end

endmodule
